// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between NUM_REQ writeback
// sources (e.g. ALU, load unit, mul/div) using round-robin arbitration.
// The write port signals are registered and drive the register file directly.
//
// Handshake: requester i transfers at a rising clk edge when
// req_valid[i] & req_ready[i] are both high. req_ready is one-hot (or zero),
// combinational from req_valid, wb_en, reset and the round-robin pointer.
// Requesters hold valid/addr/data stable until they see ready.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   wb_en                 global writeback enable (0 = no grants)
//   req_valid/addr/data   packed per-requester write requests
//   req_ready             one-hot grant
//   regwrite, reg_write_address, data_wb   registered register-file write port
//   reserve_valid/addr    register reservation strobe (scoreboard build only)
//   busy                  per-register pending-write flags
//
// Optional feature: define WB_SCOREBOARD_EN to build the busy scoreboard.
// Without it busy is tied to zero and the reservation inputs are ignored.

module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wb_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        regwrite,
    output logic [ADDR_W-1:0]           reg_write_address,
    output logic [DATA_W-1:0]           data_wb,
    input  logic                        reserve_valid,
    input  logic [ADDR_W-1:0]           reserve_addr,
    output logic [(1<<ADDR_W)-1:0]      busy
);

    localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int NREG  = 1 << ADDR_W;
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_found;
    logic [NUM_REQ-1:0] grant_oh;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    logic               regwrite_q, regwrite_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;

    // Round-robin search: start one past the last granted index and wrap.
    always_comb begin : arb_search
        int               idx;
        logic [IDX_W-1:0] cand;
        grant_idx   = ptr_q;
        grant_found = 1'b0;
        grant_oh    = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % NUM_REQ;
            cand = IDX_W'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant_found    = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

    // No grants while frozen or in reset; a grant always pairs with a valid.
    assign transfer  = grant_found && wb_en && !reset;
    assign req_ready = transfer ? grant_oh : '0;

    assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

    always_comb begin
        ptr_d      = ptr_q;
        regwrite_d = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        if (transfer) begin
            ptr_d      = grant_idx;
            // Writes to $zero are accepted but never reach the register file.
            regwrite_d = (sel_addr != '0);
            addr_d     = sel_addr;
            data_d     = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= PTR_RST;
            regwrite_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign regwrite          = regwrite_q;
    assign reg_write_address = addr_q;
    assign data_wb           = data_q;

`ifdef WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q, busy_d;

    // Clear applied first so a same-edge reservation of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (transfer && (sel_addr != '0)) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (reserve_valid && (reserve_addr != '0)) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic unused_reserve;
    assign unused_reserve = ^{reserve_valid, reserve_addr};
    assign busy = {NREG{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter (NUM_REQ=3, ADDR_W=5, DATA_W=32).
// Stimulus is driven on the falling edge; every expected register-file write
// is pushed into exp_q when its grant is issued, and a monitor pops and
// compares whenever regwrite is seen high just after a rising edge.

module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    logic                        clk;
    logic                        reset;
    logic                        wb_en;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ*DATA_W-1:0]   req_data;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        regwrite;
    logic [ADDR_W-1:0]           reg_write_address;
    logic [DATA_W-1:0]           data_wb;
    logic                        reserve_valid;
    logic [ADDR_W-1:0]           reserve_addr;
    logic [(1<<ADDR_W)-1:0]      busy;

    regfile_wb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_en            (wb_en),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .regwrite         (regwrite),
        .reg_write_address(reg_write_address),
        .data_wb          (data_wb),
        .reserve_valid    (reserve_valid),
        .reserve_addr     (reserve_addr),
        .busy             (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int n_push   = 0;
    int n_pulse  = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] rf_model [0:(1<<ADDR_W)-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back({a, d});
        n_push++;
    endtask

    // Register file model: $zero is hard-wired.
    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) rf_model[i] = '0;
    end
    always @(posedge clk) begin
        if (regwrite && reg_write_address != '0) rf_model[reg_write_address] <= data_wb;
    end

    // Monitor: every regwrite pulse must match the oldest expected write.
    always @(posedge clk) begin
        #1;
        if (regwrite === 1'b1) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'({reg_write_address, data_wb}), 64'h0);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("wb_port", 64'({reg_write_address, data_wb}), 64'(e));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver helpers ----------------
    localparam logic [DATA_W-1:0] D0 = 32'h1111_0000;
    localparam logic [DATA_W-1:0] D1 = 32'h2222_0001;
    localparam logic [DATA_W-1:0] D2 = 32'h3333_0002;

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic load_all3();
        set_req(0, 5'd1, D0);
        set_req(1, 5'd2, D1);
        set_req(2, 5'd3, D2);
        req_valid = 3'b111;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DATA_W-1:0] dtab [0:2];
        dtab[0] = D0; dtab[1] = D1; dtab[2] = D2;

        reset = 1'b1; wb_en = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        reserve_valid = 1'b0; reserve_addr = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_regwrite", 64'(regwrite), 64'd0);
        check("rst_addr", 64'(reg_write_address), 64'd0);
        check("rst_data", 64'(data_wb), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        req_valid = 3'b111;
        #1 check("rst_ready_blocked", 64'(req_ready), 64'd0);

        // Single write from requester 0
        reset = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'hAABB_CCDD);
        #1 check("t1_ready", 64'(req_ready), 64'b001);
        expect_write(5'd5, 32'hAABB_CCDD);
        @(negedge clk);
        req_valid = '0;
        check("t1_regwrite_hi", 64'(regwrite), 64'd1);
        @(negedge clk);
        check("t1_regwrite_pulse", 64'(regwrite), 64'd0);
        check("t1_rf5", 64'(rf_model[5]), 64'hAABB_CCDD);

        // Reset so the pointer starts back at requester 0
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Round robin across all three for six cycles
        load_all3();
        for (int k = 0; k < 6; k++) begin
            #1 check("rr_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
            expect_write(5'(k % 3 + 1), dtab[k % 3]);
            @(negedge clk);
            check("rr_regwrite_hi", 64'(regwrite), 64'd1);
        end

        // Write to $zero by requester 1 (pointer at 2 -> search starts at 0)
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'hFFFF_FFFF);
        #1 check("z_ready", 64'(req_ready), 64'b010);
        @(negedge clk);
        check("z_regwrite", 64'(regwrite), 64'd0);
        check("z_addr", 64'(reg_write_address), 64'd0);
        check("z_data", 64'(data_wb), 64'hFFFF_FFFF);
        check("z_rf0", 64'(rf_model[0]), 64'd0);
        load_all3();
        #1 check("z_next_grant", 64'(req_ready), 64'b100);
        expect_write(5'd3, D2);
        @(negedge clk);

        // Freeze: already-registered write still issues, no new grants
        wb_en = 1'b0;
        check("frz_inflight", 64'(regwrite), 64'd1);
        for (int k = 0; k < 3; k++) begin
            #1 check("frz_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            check("frz_regwrite", 64'(regwrite), 64'd0);
        end
        wb_en = 1'b1;
        #1 check("frz_resume", 64'(req_ready), 64'b001);
        expect_write(5'd1, D0);
        @(negedge clk);

        // Reset in the middle of a stream
        #1 check("mid_ready", 64'(req_ready), 64'b010);
        expect_write(5'd2, D1);
        @(negedge clk);
        reset = 1'b1;
        #1 check("mid_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("mid_rst_regwrite", 64'(regwrite), 64'd0);
        check("mid_rst_addr", 64'(reg_write_address), 64'd0);
        check("mid_rst_data", 64'(data_wb), 64'd0);
        reset = 1'b0;
        #1 check("mid_rst_ptr", 64'(req_ready), 64'b001);
        expect_write(5'd1, D0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);

`ifdef WB_SCOREBOARD_EN
        reserve_valid = 1'b1; reserve_addr = 5'd10;
        @(negedge clk);
        reserve_valid = 1'b0;
        check("sb_set", 64'(busy[10]), 64'd1);
        req_valid = 3'b001;
        set_req(0, 5'd10, 32'h1234_5678);
        #1 check("sb_wr_ready", 64'(req_ready), 64'b001);
        expect_write(5'd10, 32'h1234_5678);
        @(negedge clk);
        check("sb_clear", 64'(busy[10]), 64'd0);
        reserve_valid = 1'b1; reserve_addr = 5'd10;
        set_req(0, 5'd10, 32'h0BAD_F00D);
        expect_write(5'd10, 32'h0BAD_F00D);
        @(negedge clk);
        req_valid = '0;
        check("sb_set_wins", 64'(busy[10]), 64'd1);
        reserve_addr = 5'd0;
        @(negedge clk);
        reserve_valid = 1'b0;
        check("sb_zero", 64'(busy), 64'(32'h0000_0400));
`else
        reserve_valid = 1'b1; reserve_addr = 5'd10;
        @(negedge clk);
        reserve_valid = 1'b0;
        check("busy_tied", 64'(busy), 64'd0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("pulse_count", 64'(n_pulse), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
